// File: rtl/dcim_pkg.sv
// rtl/dcim_pkg.sv - shared types and sizing helpers for the DCIM MAC engine
package dcim_pkg;

    typedef enum logic {
        LOAD    = 1'b0,
        COMPUTE = 1'b1
    } state_t;

    typedef enum logic {
        MODE_MUL = 1'b0,
        MODE_MAC = 1'b1
    } mode_t;

    // Wide enough to sum DEPTH full-scale products without overflow
    function automatic int acc_width(input int data_width, input int addr_width);
        return 2 * data_width + addr_width;
    endfunction

    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/dcim_lane.sv
// rtl/dcim_lane.sv - one compute lane: weight array, multiplier and accumulator
module dcim_lane
    import dcim_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 64,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int ACC_WIDTH  = acc_width(DATA_WIDTH, ADDR_WIDTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_wr_en,
    input  logic [ADDR_WIDTH-1:0]   i_wr_addr,
    input  logic [DATA_WIDTH-1:0]   i_wr_data,
    input  logic [ADDR_WIDTH-1:0]   i_rd_addr,
    input  logic [DATA_WIDTH-1:0]   i_operand,
    input  logic                    i_acc_step,
    input  logic                    i_acc_first,
    input  logic                    i_acc_clear,
    output logic [2*DATA_WIDTH-1:0] o_product,
    output logic [ACC_WIDTH-1:0]    o_sum
);

    logic [DATA_WIDTH-1:0]   r_weight [DEPTH];
    logic [ACC_WIDTH-1:0]    r_acc;
    logic [ACC_WIDTH-1:0]    w_base;
    logic [2*DATA_WIDTH-1:0] w_op_ext;
    logic [2*DATA_WIDTH-1:0] w_wt_ext;

    // Weight storage behaves like SRAM: never cleared by reset
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_weight[i_wr_addr] <= i_wr_data;
        end
    end

    assign w_op_ext  = {{DATA_WIDTH{1'b0}}, i_operand};
    assign w_wt_ext  = {{DATA_WIDTH{1'b0}}, r_weight[i_rd_addr]};
    assign o_product = w_op_ext * w_wt_ext;
    assign w_base    = i_acc_first ? '0 : r_acc;
    assign o_sum     = w_base + ACC_WIDTH'(o_product);

    always_ff @(posedge clk) begin
        if (!rst_n || i_acc_clear) begin
            r_acc <= '0;
        end else if (i_acc_step) begin
            r_acc <= o_sum;
        end
    end

endmodule

// File: rtl/dcim_mac_engine.sv
// rtl/dcim_mac_engine.sv - multi-lane DCIM engine: weight load, MUL/MAC compute, stream handshake
module dcim_mac_engine
    import dcim_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 64,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int LANES      = 2,
    parameter int ACC_WIDTH  = acc_width(DATA_WIDTH, ADDR_WIDTH)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         pe_ce,
    input  logic                         init_enable,
    input  logic                         mode,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [LANES*DATA_WIDTH-1:0]  data_in,
    output logic                         init_done,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [LANES*ACC_WIDTH-1:0]   data_out,
    output logic                         out_last
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    state_t                       r_state;
    state_t                       w_state_nxt;
    logic [ADDR_WIDTH-1:0]        r_wr_ptr;
    logic [ADDR_WIDTH-1:0]        r_addr;
    logic                         r_init_done;
    mode_t                        r_mode;
    logic                         r_out_valid;
    logic                         r_out_last;
    logic [LANES*ACC_WIDTH-1:0]   r_data_out;

    logic                         w_in_ready;
    logic                         w_accept;
    logic                         w_load_beat;
    logic                         w_load_done;
    logic                         w_comp_beat;
    logic                         w_reload;
    logic                         w_first;
    logic                         w_last;
    mode_t                        w_mode;
    logic                         w_mac;
    logic                         w_emit;
    logic [2*DATA_WIDTH-1:0]      w_prod [LANES];
    logic [ACC_WIDTH-1:0]         w_sum  [LANES];
    logic [LANES*ACC_WIDTH-1:0]   w_result;

    assign w_in_ready  = rst_n & pe_ce &
                         ((r_state == LOAD) ? init_enable
                                            : (!init_enable & (!r_out_valid | out_ready)));
    assign w_accept    = in_valid & w_in_ready;
    assign w_load_beat = w_accept & (r_state == LOAD);
    assign w_load_done = w_load_beat & (r_wr_ptr == LAST_ADDR);
    assign w_comp_beat = w_accept & (r_state == COMPUTE);
    // A reload waits until the last result has been taken downstream
    assign w_reload    = (r_state == COMPUTE) & pe_ce & init_enable & !r_out_valid;
    assign w_first     = (r_addr == '0);
    assign w_last      = (r_addr == LAST_ADDR);
    assign w_mode      = w_first ? mode_t'(mode) : r_mode;
    assign w_mac       = (w_mode == MODE_MAC);
    assign w_emit      = w_comp_beat & (!w_mac | w_last);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            LOAD:    if (w_load_done) w_state_nxt = COMPUTE;
            COMPUTE: if (w_reload)    w_state_nxt = LOAD;
            default: w_state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_addr      <= '0;
            r_init_done <= 1'b0;
            r_mode      <= MODE_MUL;
        end else begin
            if (w_reload) begin
                r_wr_ptr    <= '0;
                r_addr      <= '0;
                r_init_done <= 1'b0;
            end
            if (w_load_beat) begin
                r_wr_ptr <= w_load_done ? '0 : r_wr_ptr + ADDR_WIDTH'(1);
                if (w_load_done) begin
                    r_init_done <= 1'b1;
                end
            end
            if (w_comp_beat) begin
                r_addr <= w_last ? '0 : r_addr + ADDR_WIDTH'(1);
                if (w_first) begin
                    r_mode <= mode_t'(mode);
                end
            end
        end
    end

    genvar k;
    generate
        for (k = 0; k < LANES; k++) begin : g_lane
            dcim_lane #(
                .DATA_WIDTH (DATA_WIDTH),
                .DEPTH      (DEPTH),
                .ADDR_WIDTH (ADDR_WIDTH),
                .ACC_WIDTH  (ACC_WIDTH)
            ) u_lane (
                .clk         (clk),
                .rst_n       (rst_n),
                .i_wr_en     (w_load_beat),
                .i_wr_addr   (r_wr_ptr),
                .i_wr_data   (data_in[lane_lsb(k, DATA_WIDTH) +: DATA_WIDTH]),
                .i_rd_addr   (r_addr),
                .i_operand   (data_in[lane_lsb(k, DATA_WIDTH) +: DATA_WIDTH]),
                .i_acc_step  (w_comp_beat & w_mac),
                .i_acc_first (w_first),
                .i_acc_clear (w_reload | (w_comp_beat & w_mac & w_last)),
                .o_product   (w_prod[k]),
                .o_sum       (w_sum[k])
            );
            assign w_result[lane_lsb(k, ACC_WIDTH) +: ACC_WIDTH] =
                w_mac ? w_sum[k] : ACC_WIDTH'(w_prod[k]);
        end
    endgenerate

    // A new result may replace one being accepted in the same cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_data_out  <= '0;
        end else if (w_emit) begin
            r_out_valid <= 1'b1;
            r_out_last  <= w_last;
            r_data_out  <= w_result;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready  = w_in_ready;
    assign init_done = r_init_done;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign data_out  = r_data_out;

endmodule
